// File: rtl/ocx_tlx_data_rd_sched.sv
// Read-side burst scheduler for the TLX VC0 (resp) / VC1 (cmd) receive data FIFOs.
// Optional: define OCX_TLX_RD_SCHED_STRICT_PRIO_EN to give VC0 strict priority over VC1.
module ocx_tlx_data_rd_sched #(
    parameter int resp_addr_width  = 8,
    parameter int cmd_addr_width   = 8,
    parameter int req_q_depth_log2 = 2
) (
    input  logic                       tlx_clk,
    input  logic                       reset,
    input  logic                       afu_tlx_resp_rd_req,
    input  logic [2:0]                 afu_tlx_resp_rd_cnt,
    input  logic                       afu_tlx_cmd_rd_req,
    input  logic [2:0]                 afu_tlx_cmd_rd_cnt,
    input  logic                       resp_data_wr_ena,
    input  logic                       cmd_data_wr_ena,
    output logic                       resp_data_fifo_rd_ena,
    output logic [resp_addr_width-1:0] resp_data_fifo_rd_ptr,
    output logic                       cmd_data_fifo_rd_ena,
    output logic [cmd_addr_width-1:0]  cmd_data_fifo_rd_ptr,
    output logic                       tlx_afu_resp_data_valid,
    output logic                       tlx_afu_cmd_data_valid,
    output logic [1:0]                 rd_sched_err
);

    localparam int QL = req_q_depth_log2;
    localparam int QD = 1 << QL;
    localparam logic [QL:0] Q_FULL = (QL+1)'(QD);
    localparam logic [resp_addr_width:0] RESP_MAX = (resp_addr_width+1)'(1 << resp_addr_width);
    localparam logic [cmd_addr_width:0]  CMD_MAX  = (cmd_addr_width+1)'(1 << cmd_addr_width);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BURST_VC0 = 2'd1,
        BURST_VC1 = 2'd2
    } state_e;

    // FSM state and burst control
    state_e     state_q;
    logic [2:0] beats_left_q;
    logic       resp_rd_ena_q;
    logic       cmd_rd_ena_q;
`ifndef OCX_TLX_RD_SCHED_STRICT_PRIO_EN
    logic       last_grant_q;   // 0: VC0 granted last, 1: VC1 granted last
`endif

    // Per-VC request queues holding the beat count of each pending burst
    logic [2:0]    q_mem_q [2][QD];
    logic [QL-1:0] q_wp_q  [2];
    logic [QL-1:0] q_rp_q  [2];
    logic [QL:0]   q_cnt_q [2];

    logic [resp_addr_width:0]   resp_avail_q;
    logic [cmd_addr_width:0]    cmd_avail_q;
    logic [resp_addr_width-1:0] resp_ptr_q;
    logic [cmd_addr_width-1:0]  cmd_ptr_q;
    logic                       resp_valid_q;
    logic                       cmd_valid_q;
    logic [1:0]                 err_q;

    logic [2:0] req_cnt [2];
    logic [2:0] head    [2];
    logic [1:0] req_vld;
    logic [1:0] legal;
    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] elig;
    logic [resp_addr_width:0] resp_eff;
    logic [cmd_addr_width:0]  cmd_eff;
    logic       arb_point;
    logic       grant_any;
    logic       grant_vc;
    logic [2:0] grant_cnt;
    logic       resp_ovf;
    logic       cmd_ovf;

    always_comb begin
        req_vld    = {afu_tlx_cmd_rd_req, afu_tlx_resp_rd_req};
        req_cnt[0] = afu_tlx_resp_rd_cnt;
        req_cnt[1] = afu_tlx_cmd_rd_cnt;
        legal      = '0;
        full       = '0;
        push       = '0;
        for (int v = 0; v < 2; v++) begin
            head[v]  = q_mem_q[v][q_rp_q[v]];
            legal[v] = (req_cnt[v] == 3'b001) || (req_cnt[v] == 3'b010) || (req_cnt[v] == 3'b100);
            full[v]  = (q_cnt_q[v] == Q_FULL);
            push[v]  = req_vld[v] && legal[v] && !full[v];
        end
    end

    // The beat on the port this cycle is still counted as resident, so it is
    // excluded when re-arbitrating on the last beat of a burst.
    assign resp_eff = resp_avail_q - (resp_addr_width+1)'(resp_rd_ena_q);
    assign cmd_eff  = cmd_avail_q - (cmd_addr_width+1)'(cmd_rd_ena_q);
    assign elig[0]  = (q_cnt_q[0] != '0) && (resp_eff >= (resp_addr_width+1)'(head[0]));
    assign elig[1]  = (q_cnt_q[1] != '0) && (cmd_eff >= (cmd_addr_width+1)'(head[1]));

    assign arb_point = (state_q == IDLE) || (beats_left_q == 3'd1);
    assign grant_any = arb_point && (|elig);
`ifdef OCX_TLX_RD_SCHED_STRICT_PRIO_EN
    assign grant_vc  = !elig[0];
`else
    assign grant_vc  = !(elig[0] && (!elig[1] || last_grant_q));
`endif
    assign grant_cnt = grant_vc ? head[1] : head[0];
    assign pop       = grant_any ? (grant_vc ? 2'b10 : 2'b01) : 2'b00;

    assign resp_ovf = resp_data_wr_ena && !resp_rd_ena_q && (resp_avail_q == RESP_MAX);
    assign cmd_ovf  = cmd_data_wr_ena && !cmd_rd_ena_q && (cmd_avail_q == CMD_MAX);

    always_ff @(posedge tlx_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            beats_left_q  <= '0;
            resp_rd_ena_q <= 1'b0;
            cmd_rd_ena_q  <= 1'b0;
`ifndef OCX_TLX_RD_SCHED_STRICT_PRIO_EN
            last_grant_q  <= 1'b1;
`endif
        end else if (arb_point) begin
            if (grant_any) begin
                state_q       <= grant_vc ? BURST_VC1 : BURST_VC0;
                beats_left_q  <= grant_cnt;
                resp_rd_ena_q <= !grant_vc;
                cmd_rd_ena_q  <= grant_vc;
`ifndef OCX_TLX_RD_SCHED_STRICT_PRIO_EN
                last_grant_q  <= grant_vc;
`endif
            end else begin
                state_q       <= IDLE;
                beats_left_q  <= '0;
                resp_rd_ena_q <= 1'b0;
                cmd_rd_ena_q  <= 1'b0;
            end
        end else begin
            beats_left_q <= beats_left_q - 3'd1;
        end
    end

    always_ff @(posedge tlx_clk) begin
        if (reset) begin
            for (int v = 0; v < 2; v++) begin
                q_wp_q[v]  <= '0;
                q_rp_q[v]  <= '0;
                q_cnt_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (push[v]) begin
                    q_mem_q[v][q_wp_q[v]] <= req_cnt[v];
                    q_wp_q[v]             <= q_wp_q[v] + QL'(1);
                end
                if (pop[v]) begin
                    q_rp_q[v] <= q_rp_q[v] + QL'(1);
                end
                case ({push[v], pop[v]})
                    2'b10:   q_cnt_q[v] <= q_cnt_q[v] + (QL+1)'(1);
                    2'b01:   q_cnt_q[v] <= q_cnt_q[v] - (QL+1)'(1);
                    default: q_cnt_q[v] <= q_cnt_q[v];
                endcase
            end
        end
    end

    always_ff @(posedge tlx_clk) begin
        if (reset) begin
            resp_avail_q <= '0;
            cmd_avail_q  <= '0;
            resp_ptr_q   <= '0;
            cmd_ptr_q    <= '0;
            resp_valid_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            err_q        <= '0;
        end else begin
            case ({resp_data_wr_ena, resp_rd_ena_q})
                2'b10:   resp_avail_q <= resp_ovf ? resp_avail_q : resp_avail_q + (resp_addr_width+1)'(1);
                2'b01:   resp_avail_q <= resp_avail_q - (resp_addr_width+1)'(1);
                default: resp_avail_q <= resp_avail_q;
            endcase
            case ({cmd_data_wr_ena, cmd_rd_ena_q})
                2'b10:   cmd_avail_q <= cmd_ovf ? cmd_avail_q : cmd_avail_q + (cmd_addr_width+1)'(1);
                2'b01:   cmd_avail_q <= cmd_avail_q - (cmd_addr_width+1)'(1);
                default: cmd_avail_q <= cmd_avail_q;
            endcase
            if (resp_rd_ena_q) resp_ptr_q <= resp_ptr_q + resp_addr_width'(1);
            if (cmd_rd_ena_q)  cmd_ptr_q  <= cmd_ptr_q + cmd_addr_width'(1);
            resp_valid_q <= resp_rd_ena_q;
            cmd_valid_q  <= cmd_rd_ena_q;
            err_q[0]     <= err_q[0] | (|(req_vld & (~legal | full)));
            err_q[1]     <= err_q[1] | resp_ovf | cmd_ovf;
        end
    end

    assign resp_data_fifo_rd_ena   = resp_rd_ena_q;
    assign cmd_data_fifo_rd_ena    = cmd_rd_ena_q;
    assign resp_data_fifo_rd_ptr   = resp_ptr_q;
    assign cmd_data_fifo_rd_ptr    = cmd_ptr_q;
    assign tlx_afu_resp_data_valid = resp_valid_q;
    assign tlx_afu_cmd_data_valid  = cmd_valid_q;
    assign rd_sched_err            = err_q;

endmodule

// File: tb/tb_ocx_tlx_data_rd_sched.sv
// Randomized + directed bench for ocx_tlx_data_rd_sched against a queue-based burst model.
module tb_ocx_tlx_data_rd_sched;
  localparam int AW   = 8;
  localparam int QD   = 4;
  localparam int MAXA = 1 << AW;

  // clock / reset
  logic tlx_clk = 1'b0;
  always #5 tlx_clk = ~tlx_clk;

  logic          reset;
  logic          afu_tlx_resp_rd_req;
  logic [2:0]    afu_tlx_resp_rd_cnt;
  logic          afu_tlx_cmd_rd_req;
  logic [2:0]    afu_tlx_cmd_rd_cnt;
  logic          resp_data_wr_ena;
  logic          cmd_data_wr_ena;
  logic          resp_data_fifo_rd_ena;
  logic [AW-1:0] resp_data_fifo_rd_ptr;
  logic          cmd_data_fifo_rd_ena;
  logic [AW-1:0] cmd_data_fifo_rd_ptr;
  logic          tlx_afu_resp_data_valid;
  logic          tlx_afu_cmd_data_valid;
  logic [1:0]    rd_sched_err;

  ocx_tlx_data_rd_sched #(
    .resp_addr_width (AW),
    .cmd_addr_width  (AW),
    .req_q_depth_log2(2)
  ) dut (
    .tlx_clk                (tlx_clk),
    .reset                  (reset),
    .afu_tlx_resp_rd_req    (afu_tlx_resp_rd_req),
    .afu_tlx_resp_rd_cnt    (afu_tlx_resp_rd_cnt),
    .afu_tlx_cmd_rd_req     (afu_tlx_cmd_rd_req),
    .afu_tlx_cmd_rd_cnt     (afu_tlx_cmd_rd_cnt),
    .resp_data_wr_ena       (resp_data_wr_ena),
    .cmd_data_wr_ena        (cmd_data_wr_ena),
    .resp_data_fifo_rd_ena  (resp_data_fifo_rd_ena),
    .resp_data_fifo_rd_ptr  (resp_data_fifo_rd_ptr),
    .cmd_data_fifo_rd_ena   (cmd_data_fifo_rd_ena),
    .cmd_data_fifo_rd_ptr   (cmd_data_fifo_rd_ptr),
    .tlx_afu_resp_data_valid(tlx_afu_resp_data_valid),
    .tlx_afu_cmd_data_valid (tlx_afu_cmd_data_valid),
    .rd_sched_err           (rd_sched_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending bursts as beat counts, resident-beat totals,
  // and the beat (if any) on the shared read port this cycle.
  int m_q0[$];
  int m_q1[$];
  int m_vc;
  int m_left;
  int m_last;
  int m_ptr[2];
  int m_avail[2];
  bit m_valid[2];
  bit m_err0;
  bit m_err1;

  task automatic model_reset();
    m_q0.delete();
    m_q1.delete();
    m_vc   = -1;
    m_left = 0;
    m_last = 1;
    for (int v = 0; v < 2; v++) begin
      m_ptr[v]   = 0;
      m_avail[v] = 0;
      m_valid[v] = 1'b0;
    end
    m_err0 = 1'b0;
    m_err1 = 1'b0;
  endtask

  function automatic bit cnt_legal(input logic [2:0] c);
    return (c == 3'd1) || (c == 3'd2) || (c == 3'd4);
  endfunction

  task automatic model_step(input bit rst, input bit rr, input logic [2:0] rc,
                            input bit cr, input logic [2:0] cc, input bit w0, input bit w1);
    bit el0, el1, f0, f1, w, r;
    int g, nxt_vc, nxt_left;
    if (rst) begin
      model_reset();
      return;
    end
    f0  = (m_q0.size() >= QD);
    f1  = (m_q1.size() >= QD);
    el0 = (m_q0.size() > 0) && ((m_avail[0] - ((m_vc == 0) ? 1 : 0)) >= m_q0[0]);
    el1 = (m_q1.size() > 0) && ((m_avail[1] - ((m_vc == 1) ? 1 : 0)) >= m_q1[0]);
    nxt_vc   = -1;
    nxt_left = 0;
    if (m_vc < 0 || m_left == 1) begin
      g = -1;
`ifdef OCX_TLX_RD_SCHED_STRICT_PRIO_EN
      if (el0) g = 0;
      else if (el1) g = 1;
`else
      if (el0 && el1) g = 1 - m_last;
      else if (el0) g = 0;
      else if (el1) g = 1;
`endif
      if (g == 0) begin
        nxt_left = m_q0.pop_front();
      end else if (g == 1) begin
        nxt_left = m_q1.pop_front();
      end
      if (g >= 0) m_last = g;
      nxt_vc = g;
    end else begin
      nxt_vc   = m_vc;
      nxt_left = m_left - 1;
    end
    if (rr) begin
      if (!cnt_legal(rc) || f0) m_err0 = 1'b1;
      else m_q0.push_back(int'(rc));
    end
    if (cr) begin
      if (!cnt_legal(cc) || f1) m_err0 = 1'b1;
      else m_q1.push_back(int'(cc));
    end
    for (int v = 0; v < 2; v++) begin
      w = (v == 0) ? w0 : w1;
      r = (m_vc == v);
      if (w && !r) begin
        if (m_avail[v] == MAXA) m_err1 = 1'b1;
        else m_avail[v]++;
      end else if (!w && r) begin
        m_avail[v]--;
      end
      m_valid[v] = r;
      if (r) m_ptr[v] = (m_ptr[v] + 1) % MAXA;
    end
    m_vc   = nxt_vc;
    m_left = nxt_left;
  endtask

  // scoreboard: every cycle the DUT outputs are compared against the model
  task automatic compare_outputs();
    check("resp_rd_ena", resp_data_fifo_rd_ena, m_vc == 0);
    check("cmd_rd_ena", cmd_data_fifo_rd_ena, m_vc == 1);
    check("rd_ena_exclusive", resp_data_fifo_rd_ena & cmd_data_fifo_rd_ena, 0);
    check("resp_rd_ptr", resp_data_fifo_rd_ptr, m_ptr[0]);
    check("cmd_rd_ptr", cmd_data_fifo_rd_ptr, m_ptr[1]);
    check("resp_valid", tlx_afu_resp_data_valid, m_valid[0]);
    check("cmd_valid", tlx_afu_cmd_data_valid, m_valid[1]);
    check("rd_sched_err", rd_sched_err, {m_err1, m_err0});
  endtask

  // driver: check current outputs, apply inputs for one clock, advance the model
  task automatic cycle(input bit rst, input bit rr, input logic [2:0] rc,
                       input bit cr, input logic [2:0] cc, input bit w0, input bit w1);
    compare_outputs();
    reset               = rst;
    afu_tlx_resp_rd_req = rr;
    afu_tlx_resp_rd_cnt = rc;
    afu_tlx_cmd_rd_req  = cr;
    afu_tlx_cmd_rd_cnt  = cc;
    resp_data_wr_ena    = w0;
    cmd_data_wr_ena     = w1;
    model_step(rst, rr, rc, cr, cc, w0, w1);
    @(posedge tlx_clk);
    @(negedge tlx_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 3'd0, 0, 3'd0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 3'd0, 0, 3'd0, 0, 0);
  endtask

  function automatic logic [2:0] rand_cnt();
    int p;
    int k;
    p = $urandom_range(0, 15);
    if (p == 0) begin
      k = $urandom_range(0, 4);
      case (k)
        0:       return 3'd0;
        1:       return 3'd3;
        2:       return 3'd5;
        3:       return 3'd6;
        default: return 3'd7;
      endcase
    end
    if (p < 6) return 3'd1;
    if (p < 11) return 3'd2;
    return 3'd4;
  endfunction

  initial begin
    reset               = 1'b1;
    afu_tlx_resp_rd_req = 1'b0;
    afu_tlx_resp_rd_cnt = 3'd0;
    afu_tlx_cmd_rd_req  = 1'b0;
    afu_tlx_cmd_rd_cnt  = 3'd0;
    resp_data_wr_ena    = 1'b0;
    cmd_data_wr_ena     = 1'b0;
    @(posedge tlx_clk);
    @(negedge tlx_clk);
    model_reset();

    // 2-beat VC0 burst out of 3 resident beats
    for (int i = 0; i < 3; i++) cycle(0, 0, 3'd0, 0, 3'd0, 1, 0);
    cycle(0, 1, 3'd2, 0, 3'd0, 0, 0);
    idle(6);

    // 4-beat request waits for the 4th resident beat
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, (i == 0), 3'd4, 0, 3'd0, 1, 0);
    idle(5);
    cycle(0, 0, 3'd0, 0, 3'd0, 1, 0);
    idle(8);

    // both VCs eligible with single-beat requests: arbitration order
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 1, 3'd1, 1, 3'd1, 1, 1);
    idle(12);

    // VC1 pointer wrap: advance to 254, then a 4-beat burst
    do_reset();
    for (int i = 0; i < 63; i++) begin
      cycle(0, 0, 3'd0, 1, 3'd4, 0, 1);
      for (int j = 0; j < 3; j++) cycle(0, 0, 3'd0, 0, 3'd0, 0, 1);
    end
    cycle(0, 0, 3'd0, 1, 3'd2, 0, 1);
    cycle(0, 0, 3'd0, 0, 3'd0, 0, 1);
    idle(6);
    cycle(0, 0, 3'd0, 1, 3'd4, 0, 1);
    for (int j = 0; j < 3; j++) cycle(0, 0, 3'd0, 0, 3'd0, 0, 1);
    idle(8);

    // request-queue overflow and illegal count
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 0, 3'd0, 1, 3'd1, 0, 0);
    idle(3);
    do_reset();
    cycle(0, 0, 3'd0, 1, 3'd3, 0, 0);
    cycle(0, 0, 3'd0, 0, 3'd0, 0, 1);
    idle(4);

    // reset during the 2nd beat of a 4-beat burst
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 3'd0, 0, 3'd0, 1, 0);
    cycle(0, 1, 3'd4, 0, 3'd0, 0, 0);
    idle(2);
    do_reset();
    idle(4);

    // available-count overflow
    do_reset();
    for (int i = 0; i < MAXA + 1; i++) cycle(0, 0, 3'd0, 0, 3'd0, 1, 0);
    idle(3);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 399) == 0),
            ($urandom_range(0, 3) == 0), rand_cnt(),
            ($urandom_range(0, 3) == 0), rand_cnt(),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0));
    end
    idle(10);
    compare_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ocx_tlx_data_rd_sched.md
Name: ocx_tlx_data_rd_sched

Overview:
Read-side scheduler for the TLX receive data FIFOs. It accepts AFU read requests for command data (VC1) and response data (VC0), and queues them per VC. It grants whole bursts only when the requested beats are resident, and drives the FIFO read enables and pointers. In this configuration the two FIFOs share one physical read port, so at most one read enable is active per cycle. The FIFO read controls feed the BDI MAC directly, and the data-valid outputs are aligned with its 1-cycle BDI output stage.

Parameters:
resp_addr_width, 8, log2 depth of the response (VC0) data FIFO in 64B beats
cmd_addr_width, 8, log2 depth of the command (VC1) data FIFO in 64B beats
req_q_depth_log2, 2, log2 of the per-VC pending-request queue depth (default 4 entries)

Ports:
tlx_clk  in  1  clock
reset  in  1  synchronous, active-high reset
afu_tlx_resp_rd_req  in  1  VC0 read request strobe, one request per asserted cycle
afu_tlx_resp_rd_cnt  in  3  VC0 beat count: 001=1, 010=2, 100=4 (64B beats)
afu_tlx_cmd_rd_req  in  1  VC1 read request strobe
afu_tlx_cmd_rd_cnt  in  3  VC1 beat count, same encoding
resp_data_wr_ena  in  1  one 64B beat written into the VC0 FIFO this cycle
cmd_data_wr_ena  in  1  one 64B beat written into the VC1 FIFO this cycle
resp_data_fifo_rd_ena  out  1  VC0 FIFO read strobe
resp_data_fifo_rd_ptr  out  resp_addr_width  VC0 read address
cmd_data_fifo_rd_ena  out  1  VC1 FIFO read strobe
cmd_data_fifo_rd_ptr  out  cmd_addr_width  VC1 read address
tlx_afu_resp_data_valid  out  1  VC0 data/BDI valid, 1 cycle after the read enable
tlx_afu_cmd_data_valid  out  1  VC1 data/BDI valid, 1 cycle after the read enable
rd_sched_err  out  2  sticky errors: [0] illegal cnt or request-queue overflow, [1] beat-counter overflow

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; read pointers 0; queues empty; available counters 0; FSM IDLE; round-robin last-grant = VC1, so VC0 wins the first tie.
  - Reset mid-burst aborts the burst immediately; no further rd_ena after the reset cycle.
- Request intake:
  - Each asserted req pushes its cnt into that VC's queue.
  - An illegal cnt (000, 011, 101, 110, 111) is dropped and sets err[0].
  - A push to a full queue is dropped and sets err[0].
  - Pushes and pops on the same queue in the same cycle are both honoured.
- Available counters, per VC, width addr_width+1, counting beats resident and not yet read:
  - +1 on wr_ena, -1 on that VC's rd_ena; both in one cycle leaves the count unchanged.
  - A write while the count equals 2**addr_width sets err[1] and the count holds.
- Eligibility: a VC is eligible when its queue is non-empty and its available count ≥ the head cnt, in beats.
- FSM states IDLE, BURST_VC0, BURST_VC1; 3-bit beat counter.
  - IDLE: if any VC is eligible, grant by round-robin. On a tie, the VC not granted last wins.
  - On grant: pop the head, load beats_left = cnt, go to BURST_VCx, assert that rd_ena in the same cycle.
  - BURST_VCx: one rd_ena per cycle; pointer +1 per beat, wrapping modulo 2**addr_width; beats_left decrements each beat.
  - Last beat (beats_left==1): re-arbitrate in that cycle. If a VC is eligible, the next burst starts the following cycle with no bubble; otherwise go to IDLE.
  - A burst is never preempted.
- rd_ena encoding:
  - resp and cmd rd_ena are never both 1.
  - rd_ptr presents the current pointer while rd_ena=1.
  - rd_ptr is held when rd_ena=0 (no increment).
- Data valid: tlx_afu_*_data_valid = rd_ena delayed by exactly 1 cycle; no other latency.
- Error bits are sticky until reset.

Optional Feature:
OCX_TLX_RD_SCHED_STRICT_PRIO_EN
- Defined: VC0 (response) has strict priority over VC1 at every arbitration point, and the round-robin state is unused. VC1 is granted only when VC0 is not eligible.
- Undefined: round-robin behaviour as described above.

Test Plan:
- Reset, 3 writes to VC0, resp req cnt=010 → resp_rd_ena cycles N and N+1 with ptr 0,1; valid at N+1 and N+2; available count = 1 afterwards.
- VC0 req cnt=100 with only 3 beats resident → no rd_ena. The 4th wr_ena makes the VC eligible; 4 consecutive rd_ena follow with ptr 0–3.
- Both VCs eligible with cnt=001, repeated 4 times → grants alternate VC0, VC1, VC0, VC1; no cycle has both rd_ena; no idle cycles between bursts. With STRICT_PRIO_EN defined, all VC0 grants precede VC1.
- VC1 ptr preset to 2**8-2 by prior traffic, req cnt=100 → ptrs 254, 255, 0, 1.
- 5 VC1 requests while no data is resident → the 5th is dropped and err[0]=1. Illegal cnt=011 → err[0]=1, no queue entry added.
- Reset asserted during the 2nd beat of a 4-beat burst → rd_ena=0 from the next cycle; pointers 0; err=0.
